// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO; multi-cycle MULT/DIV with busy for D-stage stalls.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built only when MDU_MADD_EN is defined.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;
  logic [63:0] prod_s, prod_u, mres;
  logic [31:0] a_abs, b_abs, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        is_mul, is_div, accept;
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
`ifdef MDU_MADD_EN
    mres   = (mdu_op == OP_MADD)  ? {hi_q, lo_q} + prod_s :
             (mdu_op == OP_MADDU) ? {hi_q, lo_q} + prod_u :
             (mdu_op == OP_MSUB)  ? {hi_q, lo_q} - prod_s :
             (mdu_op == OP_MSUBU) ? {hi_q, lo_q} - prod_u :
             (mdu_op == OP_MULT)  ? prod_s : prod_u;
    is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
             (mdu_op >= OP_MADD && mdu_op <= OP_MSUBU);
`else
    mres   = (mdu_op == OP_MULT) ? prod_s : prod_u;
    is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`endif
    is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    a_abs  = A[31] ? -A : A;
    b_abs  = B[31] ? -B : B;
    q_mag  = (B == 32'd0) ? 32'd0 : a_abs / b_abs;
    r_mag  = (B == 32'd0) ? 32'd0 : a_abs % b_abs;
    q_s    = (A[31] ^ B[31]) ? -q_mag : q_mag;
    r_s    = A[31] ? -r_mag : r_mag;
    q_u    = (B == 32'd0) ? 32'd0 : A / B;
    r_u    = (B == 32'd0) ? 32'd0 : A % B;
    accept = start && !busy_q;
    cnt_d  = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    pend_d = pend_q;
    wr_d   = wr_q;
    hi_d   = (cnt_q == 4'd1 && wr_q) ? pend_q[63:32] : hi_q;
    lo_d   = (cnt_q == 4'd1 && wr_q) ? pend_q[31:0]  : lo_q;
    if (accept && is_mul) begin
      cnt_d  = 4'(MULT_CYCLES);
      pend_d = mres;
      wr_d   = 1'b1;
    end else if (accept && is_div) begin
      cnt_d  = 4'(DIV_CYCLES);
      pend_d = (mdu_op == OP_DIV) ? {r_s, q_s} : {r_u, q_u};
      wr_d   = (B != 32'd0);
    end else if (accept && mdu_op == OP_MTHI) begin
      hi_d = A;
    end else if (accept && mdu_op == OP_MTLO) begin
      lo_d = A;
    end
    busy_d = (cnt_d != 4'd0);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 4'd0;
      pend_q <= 64'd0;
      wr_q   <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      wr_q   <= wr_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
